// File: rtl/pdm_tx_pkg.sv
// Shared types, widths and header packing for the pdm_pkt_tx packet transmitter.
package pdm_tx_pkg;

    localparam int unsigned PDM_LEN_W   = 6;
    localparam int unsigned PDM_DEST_W  = 2;
    localparam int unsigned PDM_MAX_LEN = 63;
    localparam int unsigned PDM_BYTE_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_HDR,
        S_PAYLOAD,
        S_WAIT_ACK
    } pdm_tx_state_e;

    typedef struct packed {
        logic [PDM_LEN_W-1:0]  len;
        logic [PDM_DEST_W-1:0] dest;
    } pdm_cmd_t;

    // Header byte is {len, dest}.
    function automatic logic [PDM_BYTE_W-1:0] pdm_pack_hdr(input pdm_cmd_t cmd);
        return PDM_BYTE_W'({cmd.len, cmd.dest});
    endfunction

endpackage

// File: rtl/pdm_tx_buf.sv
// 63x8 payload buffer: append-only writes, rewindable read pointer, bulk clear.
module pdm_tx_buf
    import pdm_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [PDM_BYTE_W-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rewind,
    input  logic                  clear,
    output logic [PDM_BYTE_W-1:0] rd_data,
    output logic [PDM_LEN_W-1:0]  count,
    output logic                  full
);

    logic [PDM_BYTE_W-1:0] mem [PDM_MAX_LEN];
    logic [PDM_LEN_W-1:0]  wr_ptr;
    logic [PDM_LEN_W-1:0]  rd_ptr;
    logic                  wr_ok;

    assign wr_ok   = wr_en & ~full;
    assign rd_data = mem[rd_ptr];
    assign count   = wr_ptr;

    // Clear wins over a same-cycle write so late loads are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PDM_LEN_W'(1);
                full   <= (wr_ptr == PDM_LEN_W'(PDM_MAX_LEN - 1));
            end
            if (rewind) begin
                rd_ptr <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + PDM_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/pdm_pkt_tx.sv
// Frames buffered payload as header + bytes onto bnd_plse/data_in and waits for ack.
// Optional retransmission on ack timeout is compiled in with PDM_TX_RETRY_EN.
module pdm_pkt_tx
    import pdm_tx_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 32,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned GAP         = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [PDM_BYTE_W-1:0] load_data,
    output logic                  load_full,
    input  logic                  cmd_valid,
    input  logic [PDM_DEST_W-1:0] cmd_dest,
    input  logic [PDM_LEN_W-1:0]  cmd_len,
    output logic                  cmd_ready,
    output logic                  bnd_plse,
    output logic [PDM_BYTE_W-1:0] data_in,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT);
    localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    if (GAP < 1 || ACK_TIMEOUT < 2 || MAX_RETRY > 255) begin : g_param_check
        $error("pdm_pkt_tx: GAP, ACK_TIMEOUT or MAX_RETRY out of range");
    end

    pdm_tx_state_e         state, state_n;
    pdm_cmd_t              cmd_q, cmd_n;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_n;
    logic [WAIT_W-1:0]     wait_cnt, wait_cnt_n;
    logic [PDM_LEN_W-1:0]  idx, idx_n;
    logic [PDM_BYTE_W-1:0] data_n;
    logic                  bnd_n, done_n, err_n;
    logic                  buf_rd, buf_rewind, buf_clear;
    logic [PDM_BYTE_W-1:0] buf_rd_data;
    logic [PDM_LEN_W-1:0]  buf_count;
    logic                  cmd_bad;

`ifdef PDM_TX_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_cnt, retry_cnt_n;
`endif

    pdm_tx_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (load_valid),
        .wr_data (load_data),
        .rd_en   (buf_rd),
        .rewind  (buf_rewind),
        .clear   (buf_clear),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .full    (load_full)
    );

    assign cmd_ready = (state == S_IDLE);
    assign cmd_bad   = (cmd_len == '0) || (cmd_len > buf_count);

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_n    = state;
        cmd_n      = cmd_q;
        gap_cnt_n  = gap_cnt;
        wait_cnt_n = wait_cnt;
        idx_n      = idx;
        data_n     = '0;
        bnd_n      = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        buf_rd     = 1'b0;
        buf_rewind = 1'b0;
        buf_clear  = 1'b0;
`ifdef PDM_TX_RETRY_EN
        retry_cnt_n = retry_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_n = 1'b1;
                    end else begin
                        cmd_n     = '{len: cmd_len, dest: cmd_dest};
                        gap_cnt_n = '0;
                        state_n   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP - 1)) begin
                    data_n  = pdm_pack_hdr(cmd_q);
                    bnd_n   = 1'b1;
                    state_n = S_HDR;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            S_HDR: begin
                data_n  = buf_rd_data;
                bnd_n   = (cmd_q.len == PDM_LEN_W'(1));
                buf_rd  = 1'b1;
                idx_n   = PDM_LEN_W'(1);
                state_n = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (idx == cmd_q.len) begin
                    wait_cnt_n = '0;
                    state_n    = S_WAIT_ACK;
                end else begin
                    data_n = buf_rd_data;
                    bnd_n  = ((idx + PDM_LEN_W'(1)) == cmd_q.len);
                    buf_rd = 1'b1;
                    idx_n  = idx + PDM_LEN_W'(1);
                end
            end
            S_WAIT_ACK: begin
                if (ack) begin
                    done_n    = 1'b1;
                    buf_clear = 1'b1;
                    state_n   = S_IDLE;
`ifdef PDM_TX_RETRY_EN
                    retry_cnt_n = '0;
`endif
                end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
`ifdef PDM_TX_RETRY_EN
                    if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt_n = retry_cnt + RETRY_W'(1);
                        buf_rewind  = 1'b1;
                        gap_cnt_n   = '0;
                        state_n     = S_GAP;
                    end else begin
                        err_n       = 1'b1;
                        buf_clear   = 1'b1;
                        retry_cnt_n = '0;
                        state_n     = S_IDLE;
                    end
`else
                    err_n     = 1'b1;
                    buf_clear = 1'b1;
                    state_n   = S_IDLE;
`endif
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cmd_q    <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            bnd_plse <= 1'b0;
            data_in  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            cmd_q    <= cmd_n;
            gap_cnt  <= gap_cnt_n;
            wait_cnt <= wait_cnt_n;
            idx      <= idx_n;
            bnd_plse <= bnd_n;
            data_in  <= data_n;
            busy     <= (state_n != S_IDLE);
            done     <= done_n;
            err      <= err_n;
        end
    end

`ifdef PDM_TX_RETRY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt <= '0;
        end else begin
            retry_cnt <= retry_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_pdm_pkt_tx.sv
// Scoreboard bench for pdm_pkt_tx: expected frame beats are queued at command time
// and compared by a negedge monitor; scenario tasks check timing and pulses inline.
module tb_pdm_pkt_tx;

    localparam int unsigned AT = 32;
    localparam int unsigned MR = 3;
    localparam int unsigned G  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_full;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dest = '0;
    logic [5:0] cmd_len = '0;
    logic       cmd_ready;
    logic       bnd_plse;
    logic [7:0] data_in;
    logic       ack = 1'b0;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct packed {
        logic       bnd;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] model_buf[$];
    int         errors = 0;
    int         checks = 0;
    bit         in_frame = 1'b0;

    pdm_pkt_tx #(.ACK_TIMEOUT(AT), .MAX_RETRY(MR), .GAP(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_full  (load_full),
        .cmd_valid  (cmd_valid),
        .cmd_dest   (cmd_dest),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .bnd_plse   (bnd_plse),
        .data_in    (data_in),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Frame monitor: pops one expected beat per frame cycle, idle cycles must be zero.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            checks++;
            if (bnd_plse) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: got bnd=1 data=%02h, no frame expected", data_in);
                end else begin
                    e = exp_q.pop_front();
                    in_frame = 1'b1;
                    if ({bnd_plse, data_in} !== e) begin
                        errors++;
                        $display("FAIL frame_header: got bnd=%b data=%02h, want bnd=%b data=%02h",
                                 bnd_plse, data_in, e.bnd, e.data);
                    end
                end
            end else if (data_in !== 8'h00) begin
                errors++;
                $display("FAIL idle_data: got data=%02h, want 00", data_in);
            end
        end else begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                in_frame = 1'b0;
                $display("FAIL frame_overrun: got bnd=%b data=%02h beyond expected frame", bnd_plse, data_in);
            end else begin
                e = exp_q.pop_front();
                if (e.bnd) in_frame = 1'b0;
                if ({bnd_plse, data_in} !== e) begin
                    errors++;
                    $display("FAIL frame_byte: got bnd=%b data=%02h, want bnd=%b data=%02h",
                             bnd_plse, data_in, e.bnd, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        step();
        load_valid = 1'b0;
        if (model_buf.size() < 63) model_buf.push_back(b);
    endtask

    task automatic send_cmd(input logic [1:0] dest, input logic [5:0] len);
        cmd_valid = 1'b1;
        cmd_dest  = dest;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [1:0] dest, input logic [5:0] len);
        logic [7:0] hdr;
        hdr = {len, dest};
        exp_q.push_back('{bnd: 1'b1, data: hdr});
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back('{bnd: (i == int'(len) - 1), data: model_buf[i]});
    endtask

    // A one-byte command on an empty buffer must be rejected.
    task automatic check_empty(input string tag);
        send_cmd(2'd0, 6'd1);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_%s: got err=%b busy=%b, want err=1 busy=0", tag, err, busy);
        end
        step();
    endtask

    // Send one packet from the model buffer, ack in WAIT_ACK cycle ack_at.
    task automatic send_and_ack(input logic [1:0] dest, input logic [5:0] len,
                                input int ack_at, input bit stray_ack, input string tag);
        int         L;
        int         ack_r;
        logic [7:0] hdr;
        logic [7:0] last;
        L     = int'(len);
        ack_r = int'(G) + 1 + L + ack_at;
        hdr   = {len, dest};
        last  = model_buf[L-1];
        push_frame(dest, len);
        send_cmd(dest, len);
        for (int r = 1; r <= ack_r + 1; r++) begin
            if (r > 1) step();
            ack = (r == ack_r) || (stray_ack && r == int'(G) + 2);
            if (r == int'(G) + 1) begin
                checks++;
                if (bnd_plse !== 1'b1 || data_in !== hdr) begin
                    errors++;
                    $display("FAIL %s_hdr_time: got bnd=%b data=%02h, want bnd=1 data=%02h",
                             tag, bnd_plse, data_in, hdr);
                end
            end
            if (r == int'(G) + 1 + L) begin
                checks++;
                if (bnd_plse !== 1'b1 || data_in !== last) begin
                    errors++;
                    $display("FAIL %s_last_time: got bnd=%b data=%02h, want bnd=1 data=%02h",
                             tag, bnd_plse, data_in, last);
                end
            end
            checks++;
            if (done !== (r == ack_r + 1)) begin
                errors++;
                $display("FAIL %s_done r=%0d: got %b, want %b", tag, r, done, (r == ack_r + 1));
            end
        end
        ack = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got cmd_ready=%b busy=%b, want 1 0", tag, cmd_ready, busy);
        end
        model_buf.delete();
        step();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({bnd_plse, data_in, cmd_ready, busy, done, err, load_full} !== {1'b0, 8'h00, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values: got bnd=%b data=%02h rdy=%b busy=%b done=%b err=%b full=%b",
                     bnd_plse, data_in, cmd_ready, busy, done, err, load_full);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        send_and_ack(2'd2, 6'd3, 4, 1'b0, "basic");
        check_empty("basic");
    endtask

    task automatic test_bad_cmd();
        send_cmd(2'd1, 6'd0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_len0: got err=%b busy=%b rdy=%b, want 1 0 1", err, busy, cmd_ready);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_len0_pulse: got err=%b, want 0", err);
        end
        load_byte(8'h77);
        load_byte(8'h88);
        send_cmd(2'd1, 6'd5);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_len_short: got err=%b busy=%b, want 1 0", err, busy);
        end
        step();
        send_and_ack(2'd1, 6'd2, 1, 1'b0, "untouched");
    endtask

    task automatic test_len1();
        load_byte(8'hA5);
        send_and_ack(2'd0, 6'd1, 1, 1'b0, "len1");
    endtask

    task automatic test_ack_boundary();
        load_byte(8'h9C);
        load_byte(8'h3E);
        send_and_ack(2'd2, 6'd2, int'(AT), 1'b1, "ack_edge");
    endtask

    task automatic test_timeout();
        int         n;
        int         p;
        logic [7:0] hdr;
`ifdef PDM_TX_RETRY_EN
        n = int'(MR) + 1;
`else
        n = 1;
`endif
        p   = int'(G) + 1 + 3 + int'(AT);
        hdr = 8'h0F;
        load_byte(8'h5A);
        load_byte(8'hC3);
        load_byte(8'h81);
        for (int a = 0; a < n; a++) push_frame(2'd3, 6'd3);
        send_cmd(2'd3, 6'd3);
        for (int r = 1; r <= n * p + 1; r++) begin
            if (r > 1) step();
            if (r > int'(G) && (r - int'(G) - 1) % p == 0 && r < n * p) begin
                checks++;
                if (bnd_plse !== 1'b1 || data_in !== hdr) begin
                    errors++;
                    $display("FAIL retry_hdr r=%0d: got bnd=%b data=%02h, want 1 %02h",
                             r, bnd_plse, data_in, hdr);
                end
            end
            checks++;
            if (err !== (r == n * p + 1) || done !== 1'b0) begin
                errors++;
                $display("FAIL timeout_err r=%0d: got err=%b done=%b, want err=%b done=0",
                         r, err, done, (r == n * p + 1));
            end
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b rdy=%b, want 0 1", busy, cmd_ready);
        end
        model_buf.delete();
        step();
        check_empty("timeout");
    endtask

    task automatic test_reset_mid_payload();
        load_byte(8'h3C);
        load_byte(8'h4D);
        load_byte(8'h5E);
        load_byte(8'h6F);
        push_frame(2'd3, 6'd4);
        send_cmd(2'd3, 6'd4);
        repeat (int'(G) + 2) step();
        checks++;
        if (data_in !== 8'h4D || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_byte: got data=%02h busy=%b, want 4d 1", data_in, busy);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bnd_plse !== 1'b0 || data_in !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got bnd=%b data=%02h busy=%b rdy=%b, want 0 00 0 1",
                     bnd_plse, data_in, busy, cmd_ready);
        end
        exp_q.delete();
        model_buf.delete();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || bnd_plse !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b bnd=%b, want 1 0", cmd_ready, bnd_plse);
        end
        check_empty("reset");
    endtask

    task automatic test_full();
        for (int i = 1; i <= 64; i++) begin
            load_byte(8'(i));
            checks++;
            if (load_full !== (i >= 63)) begin
                errors++;
                $display("FAIL load_full i=%0d: got %b, want %b", i, load_full, (i >= 63));
            end
        end
        send_and_ack(2'd1, 6'd63, 2, 1'b0, "full");
        checks++;
        if (load_full !== 1'b0) begin
            errors++;
            $display("FAIL full_cleared: got %b, want 0", load_full);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_cmd();
        test_len1();
        test_ack_boundary();
        test_timeout();
        test_reset_mid_payload();
        test_full();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frames_missing: got %0d beats unsent, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdm_pkt_tx.md
# pdm_pkt_tx

Packet transmitter for the input side of the packet distribution core. It takes payload bytes and a send command from the host side and frames them onto the core's `bnd_plse`/`data_in` input as one header byte plus payload. It then waits for the core's `ack` and reports completion or failure, with optional automatic retransmission. It sits between the stimulus/host logic and `pdm_core`, and is the initiator end of the interface the core receives.

## Interface
Parameters:
- `ACK_TIMEOUT`, 32: cycles waited in WAIT_ACK before declaring a timeout (≥ 2).
- `MAX_RETRY`, 3: retransmissions after the first attempt (used only with retry compiled in).
- `GAP`, 2: idle cycles with `bnd_plse` = 0 before any transmission or retransmission (≥ 1).

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `load_valid`  in  1  — write `load_data` into the payload buffer at the next write slot.
- `load_data`  in  8  — payload byte.
- `load_full`  out  1  — buffer holds 63 bytes; loads are ignored while high.
- `cmd_valid`  in  1  — send request.
- `cmd_dest`  in  2  — destination port 0..3.
- `cmd_len`  in  6  — payload length 1..63.
- `cmd_ready`  out  1  — high only in IDLE.
- `bnd_plse`  out  1  — packet boundary strobe to the core.
- `data_in`  out  8  — byte to the core.
- `ack`  in  1  — core acknowledge.
- `busy`  out  1  — state ≠ IDLE.
- `done`  out  1  — one-cycle pulse: packet acknowledged.
- `err`  out  1  — one-cycle pulse: bad command or final timeout.

## Operation
- Header byte: `{cmd_len[5:0], cmd_dest[1:0]}`.
- Frame: header, then `cmd_len` payload bytes in load order. `bnd_plse` = 1 on the header cycle and on the last payload byte, 0 otherwise.
- A command is accepted when `cmd_valid & cmd_ready`.
  - `cmd_len` = 0, or `cmd_len` > bytes loaded: `err` pulses the next cycle. Nothing is transmitted, the buffer is untouched, and the block stays in IDLE.
- State machine:
  - IDLE → GAP on a valid command (dest/len latched).
  - GAP (`GAP` cycles) → HDR.
  - HDR (1 cycle) → PAYLOAD.
  - PAYLOAD (`len` cycles; read pointer advances each cycle) → WAIT_ACK.
  - WAIT_ACK on `ack` = 1 → IDLE. `done` pulses, the buffer empties (write/read pointers cleared).
  - WAIT_ACK on timeout → RETRY or error (see Configuration).
- `ack` is sampled only in WAIT_ACK; `ack` in any other state is ignored.
- Loads are accepted in every state. Bytes loaded during a transmission are appended beyond the packet's bytes, but the successful-completion clear discards them; the host must load after `done`.
- Reset values: `bnd_plse` 0, `data_in` 0, `cmd_ready` 1, `busy` 0, `done` 0, `err` 0, `load_full` 0; state IDLE, buffer empty, retry count 0.
- Reset mid-packet forces outputs to their reset values immediately (asynchronous). No partial frame resumes.

## Timing
- Command accepted at edge T:
  - GAP covers T+1 … T+GAP.
  - Header is driven during cycle T+GAP+1.
  - Payload byte k (1-based) is driven during T+GAP+1+k.
  - The last byte is at T+GAP+1+len.
- WAIT_ACK starts the cycle after the last byte, with `data_in` = 0 and `bnd_plse` = 0.
  - If `ack` is sampled high in WAIT_ACK cycle n (1..ACK_TIMEOUT), `done` is high in the following cycle and `cmd_ready` is high in that same cycle.
  - If there is no `ack` by WAIT_ACK cycle ACK_TIMEOUT, the timeout takes effect at the next edge.
- `ack` arriving on the same cycle the timeout expires counts as success.
- `len` = 1: the header and byte 1 both carry `bnd_plse`, so two consecutive strobed cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs except `cmd_ready`, which is state-decoded.

## Configuration
- `PDM_TX_RETRY_EN` defined:
  - A timeout with retry count < MAX_RETRY increments the count, rewinds the read pointer to 0, and re-enters GAP; the frame is resent identically.
  - A timeout with count = MAX_RETRY pulses `err`, empties the buffer, and returns to IDLE.
  - The count clears on return to IDLE.
- `PDM_TX_RETRY_EN` undefined: any timeout pulses `err`, empties the buffer, and returns to IDLE. The retry counter and rewind logic are absent.

## Structure
- Package `pdm_tx_pkg`:
  - state enum (IDLE, GAP, HDR, PAYLOAD, WAIT_ACK);
  - `PDM_LEN_W` = 6, `PDM_DEST_W` = 2, `PDM_MAX_LEN` = 63;
  - header pack function.
- Sub-module `pdm_tx_buf`: 63×8 payload RAM with write pointer, read pointer, rewind, clear, count, and full flag.

## Test plan
- Load 0x11,0x22,0x33; command dest 2, len 3; `ack` high in WAIT_ACK cycle 4 → frame 0x0E(strobe),0x11,0x22,0x33(strobe); `done` once; buffer empty.
- Command len 0, then len 5 with 2 bytes loaded → `err` pulse each time; `bnd_plse` never asserts.
- `ack` never asserted, retry enabled, MAX_RETRY=3 → 4 identical frames each preceded by GAP idle cycles, then one `err`; retry disabled → 1 frame then `err`.
- len 1, dest 0, byte 0xA5 → 0x04 then 0xA5 on consecutive cycles, both with `bnd_plse`=1.
- `reset` asserted mid-PAYLOAD → `bnd_plse`/`data_in` 0 in the same cycle, `cmd_ready`=1 after release, buffer empty.
- Load 64 bytes → `load_full`=1 after the 63rd; the 64th is ignored; len-63 packet sends the first 63 bytes.
